// File: rtl/sa_ram_rd_streamer.sv
// Burst read client for a 2-stage registered-output RAM: turns (addr, len) commands
// into RAM read-port strobes and a zero-bubble valid/ready data stream.
module sa_ram_rd_streamer #(
  parameter int AW = 5,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  // Handshakes: a command transfers on a cycle with cmd_valid & cmd_ready, a beat on a
  // cycle with out_valid & out_ready; a held beat keeps data/last stable until taken.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          v1_q, v1_d;
  logic          l1_q, l1_d;
  logic          v2_q, v2_d;
  logic          l2_q, l2_d;

  logic adv1;
  logic adv2;
  logic ore;
  logic re;
  logic accept;
  logic last_issue;
  logic pipe_empty;

  // Stage advance chain: the output register frees first, then the address stage.
  always_comb begin
    adv2       = !v2_q | out_ready;
    ore        = v1_q & adv2;
    adv1       = !v1_q | ore;
    re         = (state_q == ST_ISSUE) & adv1;
    accept     = (state_q == ST_IDLE) & cmd_valid;
    last_issue = (rem_q == '0);
    pipe_empty = !v1_q & !v2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rem_q   <= '0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      v2_q    <= 1'b0;
      l2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rem_q   <= rem_d;
      v1_q    <= v1_d;
      l1_q    <= l1_d;
      v2_q    <= v2_d;
      l2_q    <= l2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (re && last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address counter wraps naturally at DEPTH; remaining counts down to zero.
  always_comb begin
    ra_d  = ra_q;
    rem_d = rem_q;
    v1_d  = v1_q;
    l1_d  = l1_q;
    v2_d  = v2_q;
    l2_d  = l2_q;
    if (accept) begin
      ra_d  = cmd_addr;
      rem_d = cmd_len;
    end else if (re) begin
      ra_d  = ra_q + AW'(1);
      rem_d = rem_q - AW'(1);
    end
    if (re) begin
      v1_d = 1'b1;
      l1_d = last_issue;
    end else if (ore) begin
      v1_d = 1'b0;
    end
    if (ore) begin
      v2_d = 1'b1;
      l2_d = l1_q;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    done      = (state_q == ST_DRAIN) & pipe_empty;
    ram_ra    = ra_q;
    ram_re    = re;
    ram_ore   = ore;
    out_valid = v2_q;
    out_last  = v2_q & l2_q;
    out_data  = ram_dout;
  end

endmodule
